packet_deframer: RTL and testbench

Receive-side counterpart to the packet framer; sits directly upstream of the MLow decoder.
- Consumes a byte stream delimited by start/end markers and validates the packet header.
- Packs the payload into 16-bit words and delivers them to the decoder over a valid/ready handshake.
- Flags malformed packets and counts good ones.

---
 rtl/packet_deframer.sv | 224 ++++++++++++++++++++++
 tb/tb_packet_deframer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_deframer.sv
// Receive-side packet deframer: validates sync/length header and packs payload bytes into 16-bit words.
// Optional trailing CRC-8 check is enabled by defining PACKET_DEFRAMER_CRC_EN.
`timescale 1ns/1ps

module packet_deframer #(
  parameter int          MAX_PAYLOAD_BYTES = 1024,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  packet_data_i,
  input  logic        packet_valid_i,
  output logic        packet_ready_o,
  input  logic        packet_start_i,
  input  logic        packet_end_i,
  output logic [15:0] word_data_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        frame_last_o,
  output logic        frame_done_o,
  output logic        error_o,
  output logic [1:0]  error_code_o,
  output logic [15:0] packet_count_o
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
`ifdef PACKET_DEFRAMER_CRC_EN
    CRC,
`endif
    DRAIN
  } state_t;

  state_t      state;
  logic [7:0]  len_hi_q;
  logic [15:0] len_q;
  logic [15:0] byte_cnt;
  logic [7:0]  half_q;

  logic        xfer;
  logic [15:0] len_word;
  logic        len_bad;
  logic        is_last;
  logic [15:0] pair_word;

  // The output register frees up in the same cycle it is consumed, so a steady stream has no bubbles.
  assign packet_ready_o = !word_valid_o | word_ready_i;
  assign xfer           = packet_valid_i & packet_ready_o;
  assign len_word       = {len_hi_q, packet_data_i};
  assign len_bad        = (len_word == 16'd0) || (len_word > MAX_LEN);
  assign is_last        = (byte_cnt == (len_q - 16'd1));
  assign pair_word      = byte_cnt[0] ? {half_q, packet_data_i} : {packet_data_i, 8'h00};

`ifdef PACKET_DEFRAMER_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_next;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    r = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign crc_next = crc8_step(crc_q, packet_data_i);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      len_hi_q       <= 8'h00;
      len_q          <= 16'h0000;
      byte_cnt       <= 16'h0000;
      half_q         <= 8'h00;
      word_data_o    <= 16'h0000;
      word_valid_o   <= 1'b0;
      frame_last_o   <= 1'b0;
      frame_done_o   <= 1'b0;
      error_o        <= 1'b0;
      error_code_o   <= 2'd0;
      packet_count_o <= 16'h0000;
`ifdef PACKET_DEFRAMER_CRC_EN
      crc_q          <= 8'h00;
`endif
    end else begin
      frame_done_o <= 1'b0;
      error_o      <= 1'b0;
      if (word_valid_o && word_ready_i) begin
        word_valid_o <= 1'b0;
        frame_last_o <= 1'b0;
      end
      if (xfer) begin
        // A start byte always restarts header parsing, aborting any packet in flight.
        if (packet_start_i) begin
`ifdef PACKET_DEFRAMER_CRC_EN
          crc_q <= 8'h00;
`endif
          if (packet_end_i) begin
            error_o      <= 1'b1;
            error_code_o <= 2'd2;
            state        <= IDLE;
          end else if (packet_data_i == SYNC_BYTE) begin
            if (state != IDLE) begin
              error_o      <= 1'b1;
              error_code_o <= 2'd2;
            end
            state <= LEN_HI;
          end else begin
            error_o      <= 1'b1;
            error_code_o <= 2'd0;
            state        <= DRAIN;
          end
        end else begin
          case (state)
            IDLE: begin
            end
            LEN_HI: begin
`ifdef PACKET_DEFRAMER_CRC_EN
              crc_q <= crc_next;
`endif
              len_hi_q <= packet_data_i;
              if (packet_end_i) begin
                error_o      <= 1'b1;
                error_code_o <= 2'd2;
                state        <= IDLE;
              end else begin
                state <= LEN_LO;
              end
            end
            LEN_LO: begin
`ifdef PACKET_DEFRAMER_CRC_EN
              crc_q <= crc_next;
`endif
              len_q    <= len_word;
              byte_cnt <= 16'h0000;
              if (len_bad) begin
                error_o      <= 1'b1;
                error_code_o <= 2'd1;
                state        <= packet_end_i ? IDLE : DRAIN;
              end else if (packet_end_i) begin
                error_o      <= 1'b1;
                error_code_o <= 2'd2;
                state        <= IDLE;
              end else begin
                state <= PAYLOAD;
              end
            end
            PAYLOAD: begin
`ifdef PACKET_DEFRAMER_CRC_EN
              crc_q <= crc_next;
`endif
              byte_cnt <= byte_cnt + 16'd1;
              if (!byte_cnt[0]) begin
                half_q <= packet_data_i;
              end
              if (byte_cnt[0] || is_last) begin
                word_data_o  <= pair_word;
                word_valid_o <= 1'b1;
                frame_last_o <= is_last;
              end
              if (is_last) begin
`ifdef PACKET_DEFRAMER_CRC_EN
                if (packet_end_i) begin
                  error_o      <= 1'b1;
                  error_code_o <= 2'd2;
                  state        <= IDLE;
                end else begin
                  state <= CRC;
                end
`else
                if (packet_end_i) begin
                  frame_done_o   <= 1'b1;
                  packet_count_o <= packet_count_o + 16'd1;
                  state          <= IDLE;
                end else begin
                  error_o      <= 1'b1;
                  error_code_o <= 2'd3;
                  state        <= DRAIN;
                end
`endif
              end else if (packet_end_i) begin
                error_o      <= 1'b1;
                error_code_o <= 2'd2;
                state        <= IDLE;
              end
            end
`ifdef PACKET_DEFRAMER_CRC_EN
            CRC: begin
              if (packet_end_i) begin
                if (packet_data_i == crc_q) begin
                  frame_done_o   <= 1'b1;
                  packet_count_o <= packet_count_o + 16'd1;
                end else begin
                  error_o      <= 1'b1;
                  error_code_o <= 2'd3;
                end
                state <= IDLE;
              end else begin
                error_o      <= 1'b1;
                error_code_o <= 2'd3;
                state        <= DRAIN;
              end
            end
`endif
            DRAIN: begin
              if (packet_end_i) begin
                state <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_deframer.sv
// Directed self-checking bench for packet_deframer; covers CRC mode too when PACKET_DEFRAMER_CRC_EN is defined.
`timescale 1ns/1ps

module tb_packet_deframer;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  packet_data_i;
  logic        packet_valid_i;
  logic        packet_ready_o;
  logic        packet_start_i;
  logic        packet_end_i;
  logic [15:0] word_data_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        frame_last_o;
  logic        frame_done_o;
  logic        error_o;
  logic [1:0]  error_code_o;
  logic [15:0] packet_count_o;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  logic [16:0] word_q[$];
  int          done_total = 0;
  int          err_total = 0;
  logic [1:0]  err_code_seen = 2'd0;
  logic [7:0]  pay[0:15];

  always #5 clk_i = ~clk_i;

  packet_deframer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .packet_data_i  (packet_data_i),
    .packet_valid_i (packet_valid_i),
    .packet_ready_o (packet_ready_o),
    .packet_start_i (packet_start_i),
    .packet_end_i   (packet_end_i),
    .word_data_o    (word_data_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .frame_last_o   (frame_last_o),
    .frame_done_o   (frame_done_o),
    .error_o        (error_o),
    .error_code_o   (error_code_o),
    .packet_count_o (packet_count_o)
  );

  // Observe handshakes and pulses mid-cycle, well away from the rising edge.
  always @(negedge clk_i) begin
    if (word_valid_o && word_ready_i) word_q.push_back({frame_last_o, word_data_o});
    if (frame_done_o) done_total++;
    if (error_o) begin
      err_total++;
      err_code_seen = error_code_o;
    end
  end

`ifdef PACKET_DEFRAMER_CRC_EN
  function automatic logic [7:0] crc_bit_serial(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] crc_frame(input int n);
    logic [7:0] c;
    c = crc_bit_serial(8'h00, 8'h00);
    c = crc_bit_serial(c, 8'(n));
    for (int i = 0; i < n; i++) c = crc_bit_serial(c, pay[i]);
    return c;
  endfunction
`endif

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int guard;
    guard = 0;
    packet_data_i  = d;
    packet_start_i = s;
    packet_end_i   = e;
    packet_valid_i = 1'b1;
    @(negedge clk_i);
    while (packet_ready_o !== 1'b1 && guard < 200) begin
      guard++;
      @(negedge clk_i);
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: packet_ready_o=%b, required 1", packet_ready_o);
    end
    @(posedge clk_i);
    #1;
    packet_valid_i = 1'b0;
    packet_start_i = 1'b0;
    packet_end_i   = 1'b0;
  endtask

  // Sends a complete well-formed packet with LEN = n taken from pay[].
  task automatic send_good(input int n);
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'(n), 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
`ifdef PACKET_DEFRAMER_CRC_EN
      send_byte(pay[i], 1'b0, 1'b0);
`else
      send_byte(pay[i], 1'b0, i == n - 1);
`endif
    end
`ifdef PACKET_DEFRAMER_CRC_EN
    send_byte(crc_frame(n), 1'b0, 1'b1);
`endif
  endtask

  task automatic settle();
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (packet_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b, expected 1", packet_ready_o);
    end
    checks++;
    if ({word_data_o, word_valid_o, frame_last_o, frame_done_o, error_o, error_code_o, packet_count_o} !== 38'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: data=%h valid=%b last=%b done=%b err=%b code=%0d count=%0d, expected all 0",
               word_data_o, word_valid_o, frame_last_o, frame_done_o, error_o, error_code_o, packet_count_o);
    end
  endtask

  task automatic test_basic();
    int wb, db, eb;
    wb = word_q.size(); db = done_total; eb = err_total;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    checks++;
    if ({word_valid_o, frame_last_o, word_data_o} !== {1'b1, 1'b0, 16'h1122}) begin
      errors++;
      $display("[TB] FAIL basic_latency: valid=%b last=%b data=%h, expected 1 0 1122", word_valid_o, frame_last_o, word_data_o);
    end
    send_byte(8'h33, 1'b0, 1'b0);
`ifdef PACKET_DEFRAMER_CRC_EN
    send_byte(8'h44, 1'b0, 1'b0);
    send_byte(crc_frame(4), 1'b0, 1'b1);
`else
    send_byte(8'h44, 1'b0, 1'b1);
`endif
    settle();
    exp_count++;
    checks++;
    if (word_q.size() != wb + 2 || word_q[wb] !== {1'b0, 16'h1122} || word_q[wb+1] !== {1'b1, 16'h3344}) begin
      errors++;
      $display("[TB] FAIL basic_words: n=%0d w0=%h w1=%h, expected 2 words 0_1122 1_3344", word_q.size() - wb, word_q[wb], word_q[wb+1]);
    end
    checks++;
    if (done_total - db != 1 || err_total - eb != 0) begin
      errors++;
      $display("[TB] FAIL basic_pulses: done=%0d err=%0d, expected 1 0", done_total - db, err_total - eb);
    end
    checks++;
    if (packet_count_o !== 16'(exp_count)) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d, expected %0d", packet_count_o, exp_count);
    end
  endtask

  task automatic test_odd_backpressure();
    int wb, db, eb;
    wb = word_q.size(); db = done_total; eb = err_total;
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
`ifdef PACKET_DEFRAMER_CRC_EN
    send_byte(8'hCC, 1'b0, 1'b0);
`else
    send_byte(8'hCC, 1'b0, 1'b1);
`endif
    word_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if ({packet_ready_o, word_valid_o, frame_last_o, word_data_o} !== {1'b0, 1'b1, 1'b1, 16'hCC00}) begin
        errors++;
        $display("[TB] FAIL odd_hold[%0d]: ready=%b valid=%b last=%b data=%h, expected 0 1 1 cc00",
                 i, packet_ready_o, word_valid_o, frame_last_o, word_data_o);
      end
    end
    @(posedge clk_i);
    #1;
    word_ready_i = 1'b1;
`ifdef PACKET_DEFRAMER_CRC_EN
    send_byte(crc_frame(3), 1'b0, 1'b1);
`endif
    settle();
    exp_count++;
    checks++;
    if (word_q.size() != wb + 2 || word_q[wb] !== {1'b0, 16'hAABB} || word_q[wb+1] !== {1'b1, 16'hCC00}) begin
      errors++;
      $display("[TB] FAIL odd_words: n=%0d w0=%h w1=%h, expected 2 words 0_aabb 1_cc00", word_q.size() - wb, word_q[wb], word_q[wb+1]);
    end
    checks++;
    if (done_total - db != 1 || err_total - eb != 0 || packet_count_o !== 16'(exp_count)) begin
      errors++;
      $display("[TB] FAIL odd_done: done=%0d err=%0d count=%0d, expected 1 0 %0d", done_total - db, err_total - eb, packet_count_o, exp_count);
    end
  endtask

  task automatic test_bad_sync();
    int wb, db, eb;
    wb = word_q.size(); db = done_total; eb = err_total;
    send_byte(8'h5A, 1'b1, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1);
    settle();
    checks++;
    if (err_total - eb != 1 || err_code_seen !== 2'd0 || word_q.size() != wb || done_total != db) begin
      errors++;
      $display("[TB] FAIL bad_sync: errs=%0d code=%0d words=%0d done=%0d, expected 1 0 0 0",
               err_total - eb, err_code_seen, word_q.size() - wb, done_total - db);
    end
    wb = word_q.size(); db = done_total;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
    send_good(4);
    settle();
    exp_count++;
    checks++;
    if (word_q.size() != wb + 2 || word_q[wb] !== {1'b0, 16'h0102} || word_q[wb+1] !== {1'b1, 16'h0304} ||
        done_total - db != 1 || packet_count_o !== 16'(exp_count)) begin
      errors++;
      $display("[TB] FAIL sync_recover: n=%0d w0=%h w1=%h done=%0d count=%0d, expected 2 0_0102 1_0304 1 %0d",
               word_q.size() - wb, word_q[wb], word_q[wb+1], done_total - db, packet_count_o, exp_count);
    end
  endtask

  task automatic test_bad_len();
    int wb, db, eb;
    wb = word_q.size(); db = done_total; eb = err_total;
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1);
    settle();
    checks++;
    if (err_total - eb != 1 || err_code_seen !== 2'd1 || word_q.size() != wb) begin
      errors++;
      $display("[TB] FAIL len_over: errs=%0d code=%0d words=%0d, expected 1 1 0", err_total - eb, err_code_seen, word_q.size() - wb);
    end
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b1);
    settle();
    checks++;
    if (err_total - eb != 2 || error_code_o !== 2'd1 || word_q.size() != wb) begin
      errors++;
      $display("[TB] FAIL len_zero: errs=%0d code=%0d words=%0d, expected 2 1 0", err_total - eb, error_code_o, word_q.size() - wb);
    end
    // LEN = 1024 is the largest legal length and must be accepted.
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    settle();
    checks++;
    if (err_total - eb != 2 || word_q.size() != wb) begin
      errors++;
      $display("[TB] FAIL len_max_ok: errs=%0d words=%0d, expected 2 0", err_total - eb, word_q.size() - wb);
    end
    pay[0] = 8'h41; pay[1] = 8'h42;
    send_good(2);
    settle();
    exp_count++;
    checks++;
    if (err_total - eb != 3 || err_code_seen !== 2'd2 || word_q.size() != wb + 1 || word_q[wb] !== {1'b1, 16'h4142} ||
        done_total - db != 1 || packet_count_o !== 16'(exp_count)) begin
      errors++;
      $display("[TB] FAIL abort_restart: errs=%0d code=%0d n=%0d w0=%h done=%0d count=%0d, expected 3 2 1 1_4142 1 %0d",
               err_total - eb, err_code_seen, word_q.size() - wb, word_q[wb], done_total - db, packet_count_o, exp_count);
    end
  endtask

  task automatic test_early_end();
    int wb, db, eb;
    wb = word_q.size(); db = done_total; eb = err_total;
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1);
    settle();
    checks++;
    if (err_total - eb != 1 || err_code_seen !== 2'd2 || word_q.size() != wb + 1 || word_q[wb] !== {1'b0, 16'h1122} || done_total != db) begin
      errors++;
      $display("[TB] FAIL early_end: errs=%0d code=%0d n=%0d w0=%h done=%0d, expected 1 2 1 0_1122 0",
               err_total - eb, err_code_seen, word_q.size() - wb, word_q[wb], done_total - db);
    end
    wb = word_q.size();
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h06, 1'b0, 1'b0);
    send_byte(8'h21, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h23, 1'b0, 1'b0);
    pay[0] = 8'h31; pay[1] = 8'h32;
    send_good(2);
    settle();
    exp_count++;
    checks++;
    if (err_total - eb != 2 || err_code_seen !== 2'd2 || word_q.size() != wb + 2 || word_q[wb] !== {1'b0, 16'h2122} ||
        word_q[wb+1] !== {1'b1, 16'h3132} || done_total - db != 1 || packet_count_o !== 16'(exp_count)) begin
      errors++;
      $display("[TB] FAIL mid_start: errs=%0d code=%0d n=%0d w0=%h w1=%h done=%0d count=%0d, expected 2 2 2 0_2122 1_3132 1 %0d",
               err_total - eb, err_code_seen, word_q.size() - wb, word_q[wb], word_q[wb+1], done_total - db, packet_count_o, exp_count);
    end
  endtask

`ifdef PACKET_DEFRAMER_CRC_EN
  task automatic test_crc();
    int wb, db, eb;
    wb = word_q.size(); db = done_total; eb = err_total;
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'hCD, 1'b0, 1'b1);
    settle();
    exp_count++;
    checks++;
    if (done_total - db != 1 || err_total != eb || word_q.size() != wb + 1 || word_q[wb] !== {1'b1, 16'h0102}) begin
      errors++;
      $display("[TB] FAIL crc_good: done=%0d errs=%0d n=%0d w0=%h, expected 1 0 1 1_0102",
               done_total - db, err_total - eb, word_q.size() - wb, word_q[wb]);
    end
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'hCE, 1'b0, 1'b1);
    settle();
    checks++;
    if (done_total - db != 1 || err_total - eb != 1 || err_code_seen !== 2'd3) begin
      errors++;
      $display("[TB] FAIL crc_bad: done=%0d errs=%0d code=%0d, expected 1 1 3", done_total - db, err_total - eb, err_code_seen);
    end
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b1);
    settle();
    checks++;
    if (done_total - db != 1 || err_total - eb != 2 || err_code_seen !== 2'd2 || packet_count_o !== 16'(exp_count)) begin
      errors++;
      $display("[TB] FAIL crc_missing: done=%0d errs=%0d code=%0d count=%0d, expected 1 2 2 %0d",
               done_total - db, err_total - eb, err_code_seen, packet_count_o, exp_count);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int wb, db, eb;
    eb = err_total;
    send_byte(SYNC, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    word_ready_i = 1'b0;
    do_reset();
    exp_count = 0;
    checks++;
    if ({packet_ready_o, word_valid_o, frame_last_o, word_data_o, error_code_o, packet_count_o} !== {1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 16'h0000} ||
        err_total != eb) begin
      errors++;
      $display("[TB] FAIL reset_mid: ready=%b valid=%b last=%b data=%h code=%0d count=%0d errs=%0d, expected 1 0 0 0000 0 0 0",
               packet_ready_o, word_valid_o, frame_last_o, word_data_o, error_code_o, packet_count_o, err_total - eb);
    end
    word_ready_i = 1'b1;
    wb = word_q.size(); db = done_total;
    pay[0] = 8'h55; pay[1] = 8'h66;
    send_good(2);
    settle();
    exp_count++;
    checks++;
    if (word_q.size() != wb + 1 || word_q[wb] !== {1'b1, 16'h5566} || done_total - db != 1 || err_total != eb ||
        packet_count_o !== 16'(exp_count)) begin
      errors++;
      $display("[TB] FAIL reset_recover: n=%0d w0=%h done=%0d errs=%0d count=%0d, expected 1 1_5566 1 0 %0d",
               word_q.size() - wb, word_q[wb], done_total - db, err_total - eb, packet_count_o, exp_count);
    end
  endtask

  initial begin
    reset_i        = 1'b1;
    packet_data_i  = 8'h00;
    packet_valid_i = 1'b0;
    packet_start_i = 1'b0;
    packet_end_i   = 1'b0;
    word_ready_i   = 1'b1;
    test_reset();
    test_basic();
    test_odd_backpressure();
    test_bad_sync();
    test_bad_len();
    test_early_end();
`ifdef PACKET_DEFRAMER_CRC_EN
    test_crc();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
